// File: rtl/int_bus_arbiter.sv
// rtl/int_bus_arbiter.sv - two-master round-robin arbiter for the 16-bit-address / 8-bit-data register bus
module int_bus_arbiter #(
    parameter int AW = 16
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          m0_req,
    output logic          m0_gnt,
    input  logic [AW-1:0] m0_address,
    input  logic [7:0]    m0_wr_data,
    input  logic          m0_write,
    input  logic          m0_read,
    output logic [7:0]    m0_rd_data,

    input  logic          m1_req,
    output logic          m1_gnt,
    input  logic [AW-1:0] m1_address,
    input  logic [7:0]    m1_wr_data,
    input  logic          m1_write,
    input  logic          m1_read,
    output logic [7:0]    m1_rd_data,

    output logic [AW-1:0] int_address,
    output logic [7:0]    int_wr_data,
    output logic          int_write,
    output logic          int_read,
    input  logic [7:0]    int_rd_data,

    output logic [1:0]    err_nogrant,
    input  logic          err_clear
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    // Master that owned the bus most recently; reset to 1 so master 0 wins first.
    logic       last;
    logic       last_nxt;

    // Master that issued the read currently travelling through the slave.
    logic       rd_owner;
    // High in the cycle the slave presents read data (one cycle after int_read).
    logic       rd_pending;

    logic       m0_strobe;
    logic       m1_strobe;
    logic [1:0] err_set;

    assign m0_gnt = (state == GNT0);
    assign m1_gnt = (state == GNT1);

    assign m0_strobe = m0_write | m0_read;
    assign m1_strobe = m1_write | m1_read;

    // A strobe from a master that does not currently own the bus is an error.
    assign err_set = {m1_strobe & (state != GNT1),
                      m0_strobe & (state != GNT0)};

    // Next-state and round-robin owner selection.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (m0_req) begin
                    state_nxt = GNT0;
                end else if (m1_req) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_req) begin
                    state_nxt = GAP;
                    last_nxt  = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_req) begin
                    state_nxt = GAP;
                    last_nxt  = 1'b1;
                end
            end
            default: begin
                // Dead cycle between owners: nobody is granted.
                state_nxt = IDLE;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Registered bus mux: the owner's address, data and strobes reach the slave one cycle later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            int_address <= '0;
            int_wr_data <= 8'h00;
            int_write   <= 1'b0;
            int_read    <= 1'b0;
        end else begin
            case (state)
                GNT0: begin
                    int_address <= m0_address;
                    int_wr_data <= m0_wr_data;
                    int_write   <= m0_write;
                    int_read    <= m0_read;
                end
                GNT1: begin
                    int_address <= m1_address;
                    int_wr_data <= m1_wr_data;
                    int_write   <= m1_write;
                    int_read    <= m1_read;
                end
                default: begin
                    // Address and data hold; only the strobes are forced low.
                    int_write <= 1'b0;
                    int_read  <= 1'b0;
                end
            endcase
        end
    end

    // Remember which master issued the read so its data returns there even if it has since released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_owner   <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= int_read;
            if (state == GNT0 && m0_read) begin
                rd_owner <= 1'b0;
            end else if (state == GNT1 && m1_read) begin
                rd_owner <= 1'b1;
            end
        end
    end

    // Read data return: capture slave data into the owning master's register only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m0_rd_data <= 8'h00;
            m1_rd_data <= 8'h00;
        end else if (rd_pending) begin
            if (rd_owner) begin
                m1_rd_data <= int_rd_data;
            end else begin
                m0_rd_data <= int_rd_data;
            end
        end
    end

    // Sticky no-grant error flags; a new error in the clearing cycle stays set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_nogrant <= 2'b00;
        end else if (err_clear) begin
            err_nogrant <= err_set;
        end else begin
            err_nogrant <= err_nogrant | err_set;
        end
    end

endmodule

// File: tb/tb_int_bus_arbiter.sv
// tb/tb_int_bus_arbiter.sv - directed scoreboard bench for int_bus_arbiter
module tb_int_bus_arbiter;

    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic          m0_gnt, m1_gnt;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic [7:0]    m0_wr_data = 8'h00, m1_wr_data = 8'h00;
    logic          m0_write = 1'b0, m1_write = 1'b0;
    logic          m0_read = 1'b0, m1_read = 1'b0;
    logic [7:0]    m0_rd_data, m1_rd_data;
    logic [AW-1:0] int_address;
    logic [7:0]    int_wr_data;
    logic          int_write, int_read;
    logic [7:0]    int_rd_data = 8'h00;
    logic [1:0]    err_nogrant;
    logic          err_clear = 1'b0;

    int passed = 0;
    int total  = 0;

    // Expected slave writes {address, data}, pushed when a granted write is driven.
    logic [23:0] wr_q[$];

    int_bus_arbiter #(.AW(AW)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_address(m0_address), .m0_wr_data(m0_wr_data),
        .m0_write(m0_write), .m0_read(m0_read), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_address(m1_address), .m1_wr_data(m1_wr_data),
        .m1_write(m1_write), .m1_read(m1_read), .m1_rd_data(m1_rd_data),
        .int_address(int_address), .int_wr_data(int_wr_data),
        .int_write(int_write), .int_read(int_read), .int_rd_data(int_rd_data),
        .err_nogrant(err_nogrant), .err_clear(err_clear)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] slave_data(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h2C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Register-file model: data for a read appears the cycle after int_read.
    logic          slv_pend = 1'b0;
    logic [AW-1:0] slv_addr = '0;
    always @(negedge clock) begin
        if (!reset) begin
            slv_pend = 1'b0;
        end else begin
            if (slv_pend) int_rd_data = slave_data(slv_addr);
            slv_pend = int_read;
            slv_addr = int_address;
        end
    end

    // Scoreboard monitor: every slave write must match the oldest expected write.
    always @(negedge clock) begin
        if (int_write) begin
            if (wr_q.size() == 0) begin
                check("unexpected_int_write", {8'h00, int_address, int_wr_data}, 32'hFFFF_FFFF);
            end else begin
                check("int_write_sb", {8'h00, int_address, int_wr_data}, {8'h00, wr_q.pop_front()});
            end
        end
    end

    initial begin
        int dead;
        int e;

        // Reset state, held while reset is low.
        step();
        step();
        check("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
        check("rst_strobes", {int_write, int_read}, 2'b00);
        check("rst_addr", int_address, 16'h0000);
        check("rst_wdata", int_wr_data, 8'h00);
        check("rst_err", err_nogrant, 2'b00);
        check("rst_rdata", {m1_rd_data, m0_rd_data}, 16'h0000);

        // 1: grant latency and write forwarding.
        reset = 1'b1;
        m0_req = 1'b1;
        step();
        check("t1_gnt", {m1_gnt, m0_gnt}, 2'b01);
        m0_write = 1'b1; m0_address = 16'h1234; m0_wr_data = 8'hA5;
        wr_q.push_back({16'h1234, 8'hA5});
        step();
        check("t1_int_write", int_write, 1'b1);
        check("t1_int_addr", int_address, 16'h1234);
        check("t1_int_wdata", int_wr_data, 8'hA5);
        m0_write = 1'b0;
        step();
        check("t1_write_drop", int_write, 1'b0);

        // 2: both requesting, m0 holds, then hands over through GAP and IDLE.
        m1_req = 1'b1;
        step();
        check("t2_hold", {m1_gnt, m0_gnt}, 2'b01);
        m0_req = 1'b0;
        step();
        check("t2_gap", {m1_gnt, m0_gnt}, 2'b00);
        step();
        check("t2_idle", {m1_gnt, m0_gnt}, 2'b00);
        step();
        check("t2_m1_gnt", {m1_gnt, m0_gnt}, 2'b10);

        // 3: m1 read, data returned two cycles after the strobe.
        m1_read = 1'b1; m1_address = 16'h0010;
        step();
        check("t3_int_read", {int_read, int_address}, {1'b1, 16'h0010});
        m1_read = 1'b0;
        step();
        check("t3_early", m1_rd_data, 8'h00);
        step();
        check("t3_m1_rdata", m1_rd_data, 8'h3C);
        check("t3_m0_rdata", m0_rd_data, 8'h00);

        // 4: non-granted strobe is blocked and flagged; clear; set wins over clear.
        m1_req = 1'b0;
        m0_req = 1'b1;
        step();
        step();
        step();
        check("t4_m0_gnt", {m1_gnt, m0_gnt}, 2'b01);
        m1_write = 1'b1; m1_address = 16'h0BAD; m1_wr_data = 8'hEE;
        step();
        m1_write = 1'b0;
        check("t4_blocked", int_write, 1'b0);
        check("t4_err", err_nogrant, 2'b10);
        err_clear = 1'b1;
        step();
        check("t4_clear", err_nogrant, 2'b00);
        m1_read = 1'b1;
        step();
        m1_read = 1'b0;
        check("t4_set_wins", err_nogrant, 2'b10);
        check("t4_read_blocked", int_read, 1'b0);
        step();
        err_clear = 1'b0;
        check("t4_clear2", err_nogrant, 2'b00);

        // 5: both request continuously, each releases after one access.
        m1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = i % 2;
            dead = 0;
            while (!(m0_gnt || m1_gnt) && dead < 8) begin
                dead++;
                step();
            end
            check($sformatf("t5_owner%0d", i), {m1_gnt, m0_gnt}, (e != 0) ? 2'b10 : 2'b01);
            if (i > 0) check($sformatf("t5_dead%0d", i), dead, 2);
            if (e == 0) begin
                m0_write = 1'b1; m0_address = 16'h0100 + 16'(i); m0_wr_data = 8'(8'h11 * i);
            end else begin
                m1_write = 1'b1; m1_address = 16'h0100 + 16'(i); m1_wr_data = 8'(8'h11 * i);
            end
            wr_q.push_back({16'h0100 + 16'(i), 8'(8'h11 * i)});
            step();
            m0_write = 1'b0;
            m1_write = 1'b0;
            if (e == 0) m0_req = 1'b0; else m1_req = 1'b0;
            step();
            if (e == 0) m0_req = 1'b1; else m1_req = 1'b1;
        end
        m1_req = 1'b0;
        check("t5_err_none", err_nogrant, 2'b00);

        // 6: reset asserted while a read is in flight.
        dead = 0;
        while (!m0_gnt && dead < 8) begin
            dead++;
            step();
        end
        check("t6_m0_gnt", {m1_gnt, m0_gnt}, 2'b01);
        m0_read = 1'b1; m0_address = 16'h0042; m1_write = 1'b1;
        step();
        m0_read = 1'b0; m1_write = 1'b0;
        check("t6_int_read", int_read, 1'b1);
        check("t6_err_before", err_nogrant, 2'b10);
        #1;
        reset = 1'b0;
        #1;
        check("t6_rst_read", int_read, 1'b0);
        check("t6_rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
        check("t6_rst_err", err_nogrant, 2'b00);
        check("t6_rst_rdata", {m1_rd_data, m0_rd_data}, 16'h0000);
        m1_req = 1'b1;
        step();
        step();
        check("t6_no_data", {m1_rd_data, m0_rd_data}, 16'h0000);
        reset = 1'b1;
        step();
        check("t6_restart", {m1_gnt, m0_gnt}, 2'b01);
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
        step();

        check("wr_q_empty", wr_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
